// File: rtl/ingress_packet_arbiter.sv
// Packet-granular round-robin merge of PORT_NUM ingress flit streams into one
// registered ingress_packet_* stream. A grant is held from start to last flit so
// packets never interleave; flits arriving without a start are dropped and counted.

`ifndef PKT_HEAD_BUS_WIDTH
`define PKT_HEAD_BUS_WIDTH 32
`endif
`ifndef PKT_DATA_BUS_WIDTH
`define PKT_DATA_BUS_WIDTH 64
`endif

module ingress_packet_arbiter #(
   parameter int unsigned PORT_NUM     = 2,
   parameter int unsigned PORT_NUM_LOG = 1,
   parameter int unsigned HEAD_WIDTH   = `PKT_HEAD_BUS_WIDTH,
   parameter int unsigned DATA_WIDTH   = `PKT_DATA_BUS_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORT_NUM-1:0]              in_valid,
   input  logic [PORT_NUM*HEAD_WIDTH-1:0]   in_head,
   input  logic [PORT_NUM*DATA_WIDTH-1:0]   in_data,
   input  logic [PORT_NUM-1:0]              in_start,
   input  logic [PORT_NUM-1:0]              in_last,
   output logic [PORT_NUM-1:0]              in_ready,
   output logic                             ingress_packet_valid,
   output logic [HEAD_WIDTH-1:0]            ingress_packet_head,
   output logic [DATA_WIDTH-1:0]            ingress_packet_data,
   output logic                             ingress_packet_start,
   output logic                             ingress_packet_last,
   input  logic                             ingress_packet_ready,
   output logic [PORT_NUM_LOG-1:0]          grant_port,
   output logic [15:0]                      drop_cnt
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned CNT_PW = PORT_NUM_LOG + 1;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_XFER = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [PORT_NUM_LOG-1:0] grant_q, grant_d;
   logic [PORT_NUM_LOG-1:0] last_grant_q, last_grant_d;
   logic                    out_valid_q, out_valid_d;
   logic [HEAD_WIDTH-1:0]   out_head_q, out_head_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_start_q, out_start_d;
   logic                    out_last_q, out_last_d;
   logic [CNT_W-1:0]        drop_q, drop_d;

   logic [PORT_NUM-1:0]     req_c;
   logic [PORT_NUM-1:0]     bad_c;
   logic [CNT_PW-1:0]       bad_cnt_c;
   logic                    win_found_c;
   logic [PORT_NUM_LOG-1:0] win_idx_c;

   logic                    sel_valid_c;
   logic [HEAD_WIDTH-1:0]   sel_head_c;
   logic [DATA_WIDTH-1:0]   sel_data_c;
   logic                    sel_start_c;
   logic                    sel_last_c;

   logic                    out_room_c;
   logic                    accept_c;
   logic [CNT_PW-1:0]       drop_add_c;
   logic [CNT_W:0]          drop_sum_c;

   // Requesters, malformed flits and their count.
   always_comb begin
      req_c     = in_valid & in_start;
      bad_c     = in_valid & ~in_start;
      bad_cnt_c = '0;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
         bad_cnt_c = bad_cnt_c + CNT_PW'(bad_c[p]);
      end
   end

   // Round-robin winner: first requester searching upward from last_grant+1.
   always_comb begin
      win_found_c = 1'b0;
      win_idx_c   = '0;
      for (int unsigned i = 1; i <= PORT_NUM; i++) begin
         for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (!win_found_c && req_c[p] &&
                (p == ((32'(last_grant_q) + i) % PORT_NUM))) begin
               win_found_c = 1'b1;
               win_idx_c   = PORT_NUM_LOG'(p);
            end
         end
      end
   end

   // Flit fields of the currently granted port.
   always_comb begin
      sel_valid_c = 1'b0;
      sel_head_c  = '0;
      sel_data_c  = '0;
      sel_start_c = 1'b0;
      sel_last_c  = 1'b0;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
         if (grant_q == PORT_NUM_LOG'(p)) begin
            sel_valid_c = in_valid[p];
            sel_head_c  = in_head[p*HEAD_WIDTH +: HEAD_WIDTH];
            sel_data_c  = in_data[p*DATA_WIDTH +: DATA_WIDTH];
            sel_start_c = in_start[p];
            sel_last_c  = in_last[p];
         end
      end
   end

   // Arbitration FSM: next state, grant bookkeeping, in_ready and drop accounting.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      in_ready     = '0;
      accept_c     = 1'b0;
      drop_add_c   = '0;
      out_room_c   = !out_valid_q || ingress_packet_ready;

      case (state_q)
         ST_ARB: begin
            in_ready   = bad_c;
            drop_add_c = bad_cnt_c;
            if (win_found_c) begin
               grant_d = win_idx_c;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            for (int unsigned p = 0; p < PORT_NUM; p++) begin
               in_ready[p] = (grant_q == PORT_NUM_LOG'(p)) && out_room_c;
            end
            accept_c = sel_valid_c && out_room_c;
            if (accept_c && sel_last_c) begin
               last_grant_d = grant_q;
               state_d      = ST_ARB;
            end
         end
      endcase
   end

   // Output pipeline stage: load on accept, empty on fire without a new flit.
   always_comb begin
      out_valid_d = out_valid_q;
      out_head_d  = out_head_q;
      out_data_d  = out_data_q;
      out_start_d = out_start_q;
      out_last_d  = out_last_q;
      if (accept_c) begin
         out_valid_d = 1'b1;
         out_head_d  = sel_head_c;
         out_data_d  = sel_data_c;
         out_start_d = sel_start_c;
         out_last_d  = sel_last_c;
      end else if (out_valid_q && ingress_packet_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Saturating drop counter.
   always_comb begin
      drop_sum_c = {1'b0, drop_q} + (CNT_W + 1)'(drop_add_c);
      drop_d     = drop_sum_c[CNT_W] ? {CNT_W{1'b1}} : drop_sum_c[CNT_W-1:0];
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ARB;
         grant_q      <= '0;
         last_grant_q <= PORT_NUM_LOG'(PORT_NUM - 1);
         out_valid_q  <= 1'b0;
         out_head_q   <= '0;
         out_data_q   <= '0;
         out_start_q  <= 1'b0;
         out_last_q   <= 1'b0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         out_valid_q  <= out_valid_d;
         out_head_q   <= out_head_d;
         out_data_q   <= out_data_d;
         out_start_q  <= out_start_d;
         out_last_q   <= out_last_d;
         drop_q       <= drop_d;
      end
   end

   assign ingress_packet_valid = out_valid_q;
   assign ingress_packet_head  = out_head_q;
   assign ingress_packet_data  = out_data_q;
   assign ingress_packet_start = out_start_q;
   assign ingress_packet_last  = out_last_q;
   assign grant_port           = grant_q;
   assign drop_cnt             = drop_q;

endmodule

// File: tb/tb_ingress_packet_arbiter.sv
// Bench for ingress_packet_arbiter: directed steps plus randomized traffic
// checked against a packet-level round-robin reference.

module tb_ingress_packet_arbiter;

   localparam int PN = 3;
   localparam int PL = 2;
   localparam int HW = 32;
   localparam int DW = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [PN-1:0]     in_valid;
   logic [PN*HW-1:0]  in_head;
   logic [PN*DW-1:0]  in_data;
   logic [PN-1:0]     in_start;
   logic [PN-1:0]     in_last;
   logic [PN-1:0]     in_ready;
   logic              ingress_packet_valid;
   logic [HW-1:0]     ingress_packet_head;
   logic [DW-1:0]     ingress_packet_data;
   logic              ingress_packet_start;
   logic              ingress_packet_last;
   logic              ingress_packet_ready;
   logic [PL-1:0]     grant_port;
   logic [15:0]       drop_cnt;

   always #5 clk = ~clk;

   ingress_packet_arbiter #(
      .PORT_NUM(PN), .PORT_NUM_LOG(PL), .HEAD_WIDTH(HW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_head(in_head), .in_data(in_data),
      .in_start(in_start), .in_last(in_last), .in_ready(in_ready),
      .ingress_packet_valid(ingress_packet_valid),
      .ingress_packet_head(ingress_packet_head),
      .ingress_packet_data(ingress_packet_data),
      .ingress_packet_start(ingress_packet_start),
      .ingress_packet_last(ingress_packet_last),
      .ingress_packet_ready(ingress_packet_ready),
      .grant_port(grant_port), .drop_cnt(drop_cnt)
   );

   typedef struct packed {
      logic [HW-1:0] h;
      logic [DW-1:0] d;
      logic          s;
      logic          l;
   } flit_t;

   flit_t pq   [PN][$];   // per-port flits still to be offered
   int    plen [PN][$];   // per-port packet lengths, for the order model
   flit_t expq [$];       // expected merged flit stream
   int    n_chk    = 0;
   int    n_pass   = 0;
   int    mdl_last = PN - 1;
   int    uid      = 0;
   int    lf;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      in_valid = '0;
      in_start = '0;
      in_last  = '0;
      in_head  = '0;
      in_data  = '0;
   endtask

   task automatic drive(input int p, input logic v, input logic s, input logic l,
                        input logic [HW-1:0] h, input logic [DW-1:0] d);
      in_valid[p]          = v;
      in_start[p]          = s;
      in_last[p]           = l;
      in_head[p*HW +: HW]  = h;
      in_data[p*DW +: DW]  = d;
   endtask

   task automatic add_pkt(input int p, input int len);
      flit_t f;
      plen[p].push_back(len);
      for (int i = 0; i < len; i++) begin
         f.h = {8'(p), 8'(len), 16'(uid)};
         f.d = {$urandom, $urandom};
         f.s = (i == 0);
         f.l = (i == len - 1);
         pq[p].push_back(f);
         uid++;
      end
   endtask

   // Reference: ports with pending packets are served in round-robin order
   // starting after the last served port; each packet goes out whole.
   task automatic build_exp();
      flit_t cq [PN][$];
      int    lq [PN][$];
      int    pick;
      int    n;
      for (int p = 0; p < PN; p++) begin
         cq[p] = pq[p];
         lq[p] = plen[p];
         plen[p].delete();
      end
      pick = 0;
      while (pick >= 0) begin
         pick = -1;
         for (int i = 1; i <= PN; i++) begin
            if (pick < 0 && lq[(mdl_last + i) % PN].size() > 0) pick = (mdl_last + i) % PN;
         end
         if (pick >= 0) begin
            n = lq[pick].pop_front();
            for (int k = 0; k < n; k++) expq.push_back(cq[pick].pop_front());
            mdl_last = pick;
         end
      end
   endtask

   task automatic run_engine(input int gap_pct, input int rdy_pct, input int lo_s,
                             input int lo_e, input int budget, output int last_fire);
      flit_t          f;
      flit_t          e;
      logic [PN-1:0]  vmask;
      logic [98:0]    cur_out;
      logic [98:0]    prev_out;
      logic           prev_hold;
      logic           fire;
      int             cyc;
      bit             busy;
      build_exp();
      cyc       = 0;
      last_fire = -1;
      prev_hold = 1'b0;
      prev_out  = '0;
      busy      = 1'b1;
      while (busy && cyc < budget) begin
         clr_in();
         vmask = '0;
         for (int p = 0; p < PN; p++) begin
            if (pq[p].size() > 0) begin
               f = pq[p][0];
               if (f.s || $urandom_range(99) >= gap_pct) begin
                  drive(p, 1'b1, f.s, f.l, f.h, f.d);
                  vmask[p] = 1'b1;
               end
            end
         end
         if (cyc >= lo_s && cyc < lo_e) ingress_packet_ready = 1'b0;
         else ingress_packet_ready = ($urandom_range(99) < rdy_pct);
         #1;
         cur_out = {ingress_packet_valid, ingress_packet_head, ingress_packet_data,
                    ingress_packet_start, ingress_packet_last};
         if (prev_hold) chk("hold_stable", cur_out, prev_out);
         if (ingress_packet_valid && !ingress_packet_ready) chk("bp_in_ready", in_ready, 0);
         chk("single_ready", $countones(in_ready) <= 1, 1);
         fire = ingress_packet_valid && ingress_packet_ready;
         if (fire) begin
            chk("exp_avail", expq.size() > 0, 1);
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("out_head", ingress_packet_head, e.h);
               chk("out_data", ingress_packet_data, e.d);
               chk("out_start_last", {ingress_packet_start, ingress_packet_last}, {e.s, e.l});
            end
            last_fire = cyc;
         end
         for (int p = 0; p < PN; p++) begin
            if (vmask[p] && in_ready[p]) void'(pq[p].pop_front());
         end
         prev_hold = ingress_packet_valid && !ingress_packet_ready;
         prev_out  = cur_out;
         @(posedge clk);
         #1;
         cyc++;
         busy = (expq.size() > 0);
         for (int p = 0; p < PN; p++) if (pq[p].size() > 0) busy = 1'b1;
      end
      chk("engine_done", busy, 0);
      expq.delete();
      for (int p = 0; p < PN; p++) pq[p].delete();
      clr_in();
      ingress_packet_ready = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $error("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clr_in();
      ingress_packet_ready = 1'b1;
      repeat (3) tick();

      // Reset state, and port 0 starts a 3-flit packet (ARB bubble cycle).
      rst = 1'b0;
      drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 64'hA1);
      #1;
      chk("rst_valid", ingress_packet_valid, 0);
      chk("rst_fields", {ingress_packet_head, ingress_packet_data,
                         ingress_packet_start, ingress_packet_last}, 0);
      chk("rst_grant", grant_port, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("t1_arb_ready", in_ready, 0);
      tick();
      #1;
      chk("t1_xfer_ready", in_ready, 3'b001);
      chk("t1_grant", grant_port, 0);
      chk("t1_no_out", ingress_packet_valid, 0);
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 32'h11, 64'hA2);
      #1;
      chk("t1_f0", {ingress_packet_valid, ingress_packet_data[7:0],
                    ingress_packet_start, ingress_packet_last}, {1'b1, 8'hA1, 2'b10});
      tick();
      drive(0, 1'b1, 1'b0, 1'b1, 32'h12, 64'hA3);
      #1;
      chk("t1_f1", {ingress_packet_valid, ingress_packet_data[7:0],
                    ingress_packet_start, ingress_packet_last}, {1'b1, 8'hA2, 2'b00});
      tick();
      clr_in();
      #1;
      chk("t1_f2", {ingress_packet_valid, ingress_packet_data[7:0],
                    ingress_packet_start, ingress_packet_last}, {1'b1, 8'hA3, 2'b01});
      chk("t1_back_arb", in_ready, 0);
      tick();
      #1;
      chk("t1_idle", ingress_packet_valid, 0);
      mdl_last = 0;
      tick();

      // Ports 0 and 1 each with two 2-flit packets, alternating grants.
      add_pkt(0, 2); add_pkt(0, 2); add_pkt(1, 2); add_pkt(1, 2);
      run_engine(0, 100, -1, -1, 200, lf);
      chk("t2_last_fire", lf, 12);

      // Backpressure for 5 cycles in the middle of a 4-flit packet.
      add_pkt(0, 4);
      run_engine(0, 100, 3, 8, 200, lf);
      chk("t3_last_fire", lf, 10);

      // Malformed flits on port 1 while in ARB.
      for (int c = 0; c < 3; c++) begin
         drive(1, 1'b1, 1'b0, 1'b0, 32'hDEAD, 64'hBAD);
         #1;
         chk("t4_drop_ready", in_ready, 3'b010);
         chk("t4_no_out", ingress_packet_valid, 0);
         tick();
      end
      clr_in();
      #1;
      chk("t4_drop_cnt", drop_cnt, 3);
      tick();
      add_pkt(1, 3);
      run_engine(0, 100, -1, -1, 200, lf);
      chk("t4_last_fire", lf, 4);
      chk("t4_drop_kept", drop_cnt, 3);
      chk("t4_grant", grant_port, 1);

      // Drop counter saturation boundary.
      for (int p = 0; p < PN; p++) drive(p, 1'b1, 1'b0, 1'b0, '0, '0);
      repeat (21843) @(posedge clk);
      #1;
      chk("sat_pre", drop_cnt, 16'd65532);
      drive(2, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      chk("sat_two", drop_cnt, 16'd65534);
      drive(2, 1'b1, 1'b0, 1'b0, '0, '0);
      tick();
      chk("sat_clip", drop_cnt, 16'hFFFF);
      tick();
      chk("sat_hold", drop_cnt, 16'hFFFF);
      clr_in();
      tick();

      // Back-to-back single-flit packets on port 0.
      for (int k = 0; k < 4; k++) add_pkt(0, 1);
      run_engine(0, 100, -1, -1, 200, lf);
      chk("t5_last_fire", lf, 8);
      chk("t5_grant", grant_port, 0);

      // Reset in the middle of a port 2 packet.
      drive(2, 1'b1, 1'b1, 1'b0, 32'h20, 64'hC0);
      tick();
      drive(2, 1'b1, 1'b0, 1'b0, 32'h21, 64'hC1);
      tick();
      drive(2, 1'b1, 1'b0, 1'b0, 32'h22, 64'hC2);
      #1;
      chk("t6_pre_grant", grant_port, 2);
      chk("t6_pre_valid", ingress_packet_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clr_in();
      #1;
      chk("t6_valid", ingress_packet_valid, 0);
      chk("t6_fields", {ingress_packet_head, ingress_packet_data,
                        ingress_packet_start, ingress_packet_last}, 0);
      chk("t6_grant", grant_port, 0);
      chk("t6_drop", drop_cnt, 0);
      chk("t6_ready", in_ready, 0);
      mdl_last = PN - 1;
      tick();
      add_pkt(1, 2);
      run_engine(0, 100, -1, -1, 200, lf);
      chk("t6_last_fire", lf, 3);
      chk("t6_new_grant", grant_port, 1);

      // Randomized traffic on all ports with gaps and backpressure.
      for (int p = 0; p < PN; p++) begin
         int np;
         np = int'($urandom_range(6, 3));
         for (int k = 0; k < np; k++) add_pkt(p, int'($urandom_range(4, 1)));
      end
      run_engine(30, 70, -1, -1, 3000, lf);
      chk("rand_drop", drop_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
